// File: rtl/brv32p_muldiv.sv
// M-extension execute unit: fixed-latency 33x33 multiplier and a 32-step
// radix-2 restoring divider sharing one result register and a small FSM.
module brv32p_muldiv #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e      state, state_nx;
  logic [4:0]  cnt;
  logic [2:0]  op_p0;
  logic [31:0] a_p0, b_p0;
  logic [31:0] rem_p0, quo_p0, dvs_p0;
  logic        q_neg_p0, r_neg_p0;

  function automatic logic [31:0] mul_calc(input logic [2:0] f_op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [32:0] ax;
    logic signed [32:0] bx;
    logic signed [63:0] prod;
    ax   = {a[31] & (f_op == OP_MULH || f_op == OP_MULHSU), a};
    bx   = {b[31] & (f_op == OP_MULH), b};
    prod = 64'(ax) * 64'(bx);
    mul_calc = (f_op == OP_MUL) ? prod[31:0] : prod[63:32];
  endfunction

  // request decode: op[2]=divide family, op[0]=unsigned, op[1]=remainder
  logic        accept, req_sgn, req_div0, req_ovf;
  logic [31:0] spc_res, a_abs, b_abs;

  assign accept   = (state == S_IDLE) && start && !flush;
  assign req_sgn  = op[2] & ~op[0];
  assign req_div0 = (rs2 == 32'd0);
  assign req_ovf  = req_sgn && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign spc_res  = req_div0 ? (op[1] ? rs1 : 32'hFFFF_FFFF)
                             : (op[1] ? 32'd0 : 32'h8000_0000);
  assign a_abs    = (req_sgn && rs1[31]) ? -rs1 : rs1;
  assign b_abs    = (req_sgn && rs2[31]) ? -rs2 : rs2;

  // one restoring step: shift in next dividend bit, keep the difference if non-negative
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nx, quo_nx, quo_fin, rem_fin;
  logic        ge;

  assign rem_sh  = {rem_p0, quo_p0[31]};
  assign diff    = rem_sh - {1'b0, dvs_p0};
  assign ge      = ~diff[32];
  assign rem_nx  = ge ? diff[31:0] : rem_sh[31:0];
  assign quo_nx  = {quo_p0[30:0], ge};
  assign quo_fin = q_neg_p0 ? -quo_nx : quo_nx;
  assign rem_fin = r_neg_p0 ? -rem_nx : rem_nx;

  assign busy  = (state == S_MUL) || (state == S_DIV);
  assign valid = (state == S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) begin
        if (op[2])             state_nx = (req_div0 || req_ovf) ? S_DONE : S_DIV;
        else if (MUL_LAT == 1) state_nx = S_DONE;
        else                   state_nx = S_MUL;
      end
      S_MUL:  if (cnt == 5'd0) state_nx = S_DONE;
      S_DIV:  if (cnt == 5'd0) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // counter and result register: reset-visible, flush leaves result untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      result <= 32'd0;
    end else if (flush) begin
      cnt <= 5'd0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          if (op[2]) begin
            if (req_div0 || req_ovf) result <= spc_res;
            else                     cnt    <= 5'd31;
          end else if (MUL_LAT == 1) begin
            result <= mul_calc(op, rs1, rs2);
          end else begin
            cnt <= 5'(MUL_LAT - 2);
          end
        end
        S_MUL: begin
          if (cnt == 5'd0) result <= mul_calc(op_p0, a_p0, b_p0);
          else             cnt    <= cnt - 5'd1;
        end
        S_DIV: begin
          if (cnt == 5'd0) result <= op_p0[1] ? rem_fin : quo_fin;
          else             cnt    <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // stage p0: latched operands and divider working registers
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= op;
      a_p0     <= rs1;
      b_p0     <= rs2;
      rem_p0   <= 32'd0;
      quo_p0   <= a_abs;
      dvs_p0   <= b_abs;
      q_neg_p0 <= req_sgn & (rs1[31] ^ rs2[31]);
      r_neg_p0 <= req_sgn & rs1[31];
    end else if (state == S_DIV) begin
      rem_p0 <= rem_nx;
      quo_p0 <= quo_nx;
    end
  end

endmodule

// File: doc/brv32p_muldiv.md
Name: brv32p_muldiv

Overview:
M-extension execute unit for the BRV32P 5-stage pipeline. Sits in EX beside the ALU and takes a muldiv operation (md_op_e encoding) with forwarded rs1/rs2 operands. Multiplies complete in a fixed short latency; divides/remainders use a 32-iteration radix-2 restoring divider. busy stalls IF/ID/EX through the hazard unit; result feeds EX/MEM under wb_sel = WB_MULDIV.

Parameters:
MUL_LAT, 2, cycles from accepted start to valid for MUL/MULH/MULHSU/MULHU; legal 1..3 (pipeline registers after 33x33 signed multiplier)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only when busy=0
op  in  3  md_op_e: MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111
rs1  in  32  operand A (dividend / multiplicand)
rs2  in  32  operand B (divisor / multiplier)
flush  in  1  abort in-flight op (branch mispredict / trap)
busy  out  1  operation in flight, start ignored
valid  out  1  one-cycle pulse, result valid
result  out  32  result, held stable until next accepted start

Behaviour:
- Reset (rst_n=0 at clock edge): state=IDLE, busy=0, valid=0, result=0, iteration counter=0. Overrides start/flush same cycle.
- FSM states: IDLE, MUL, DIV, DONE. busy = (state != IDLE) && !valid-cycle; i.e. busy high from cycle N+1 through cycle before valid.
- Accept: in IDLE, start=1 at edge of cycle N latches op, rs1, rs2. start while busy=1 or in valid cycle ignored (no queueing). start and flush same cycle in IDLE: flush wins, nothing accepted.
- Multiply: operands extended to 33 bits (rs1 signed for MULH/MULHSU, rs2 signed for MULH only), 66-bit product. MUL -> product[31:0]; others -> product[63:32]. valid at cycle N+MUL_LAT.
- Divide special cases, resolved without iterating, valid at N+1:
  - rs2==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - DIV/REM signed with rs1=0x80000000, rs2=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
- Divide normal: signed ops take |rs1|, |rs2|; record quotient sign = sign(rs1) XOR sign(rs2), remainder sign = sign(rs1). Counter 31 down to 0, one quotient bit per cycle (shift remainder left, subtract divisor, restore if negative). Sign correction applied on final load into result. valid at N+33 exactly, independent of operand values.
- DONE: valid=1 for exactly one cycle, then IDLE. New start accepted in the cycle after valid (N+lat+1) at the earliest.
- Flush: any state, next edge -> IDLE, busy=0, counter cleared, valid never asserted for aborted op; result keeps prior value.
- result width rules: all arithmetic two's complement modulo 2^32; no exceptions raised, no overflow flag.
- op bits outside the 8 encodings impossible (3-bit field fully decoded).

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), MUL_LAT=2, start at N -> valid at N+2, result=0xFFFFFFEB; busy high at N+1 only.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> valid at N+33, result=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at N+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1; REM same -> 0.
- DIVU started at N, flush at N+10 -> busy=0 at N+11, no valid pulse through N+40; start MUL at N+11 accepted, valid at N+13.
- start with new operands held high every cycle during a DIV -> ignored; single valid at N+33 with original result; rst_n=0 at N+5 -> busy=0, valid=0, result=0 next cycle.
